// File: rtl/nibble_packer_pkg.sv
// Shared widths and the packed word type for the nibble packer.
package nibble_packer_pkg;

   localparam int NIBBLE_W         = 4;
   localparam int WORD_W           = 16;
   localparam int NIBBLES_PER_WORD = 4;

   typedef logic [WORD_W-1:0] word_t;

   function automatic logic word_parity(input word_t w);
      return ^w;
   endfunction

endpackage

// File: rtl/nibble_packer_fifo.sv
// Synchronous FIFO, DEPTH words (power of two), async active-high reset.
// Head data reads as zero while empty so outputs are clean after reset.
module nibble_packer_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is accepted only when a pop frees the slot.
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/nibble_packer.sv
// Packs 4-bit nibbles little-endian into 16-bit words and queues them in a FIFO.
// Optional macro NIBBLE_PACKER_PARITY_EN adds parity_o stored with each word.
module nibble_packer
   import nibble_packer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_i,
   input  logic [3:0]               data_i,
   input  logic                     flush_i,
   input  logic                     ready_i,
   output logic                     valid_o,
   output logic [15:0]              data_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o
`ifdef NIBBLE_PACKER_PARITY_EN
   ,
   output logic                     parity_o
`endif
);

`ifdef NIBBLE_PACKER_PARITY_EN
   localparam int FIFO_W = WORD_W + 1;
`else
   localparam int FIFO_W = WORD_W;
`endif

   logic [1:0]        count;
   word_t             partial;
   word_t             merged;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [FIFO_W-1:0] fifo_wdata;
   logic [FIFO_W-1:0] fifo_rdata;

   // Current nibble is merged first so a same-cycle flush includes it.
   always_comb begin
      merged = partial;
      if (valid_i)
         merged[count*NIBBLE_W +: NIBBLE_W] = data_i;
   end

   assign push = (valid_i && count == 2'd3) ||
                 (flush_i && (valid_i || count != '0));
   assign pop  = ready_i && !empty;

`ifdef NIBBLE_PACKER_PARITY_EN
   assign fifo_wdata = {word_parity(merged), merged};
   assign parity_o   = fifo_rdata[WORD_W];
`else
   assign fifo_wdata = merged;
`endif

   assign data_o  = fifo_rdata[WORD_W-1:0];
   assign valid_o = !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         partial    <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (push) begin
            count   <= '0;
            partial <= '0;
         end else if (valid_i) begin
            count   <= count + 2'd1;
            partial <= merged;
         end
         if (push && full && !pop)
            overflow_o <= 1'b1;
      end
   end

   nibble_packer_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty),
      .level (level_o)
   );

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer (DEPTH=4).
module tb_nibble_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [3:0]  data_i;
   logic        flush_i;
   logic        ready_i;
   logic        valid_o;
   logic [15:0] data_o;
   logic [2:0]  level_o;
   logic        overflow_o;
`ifdef NIBBLE_PACKER_PARITY_EN
   logic        parity_o;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   nibble_packer #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .data_i     (data_i),
      .flush_i    (flush_i),
      .ready_i    (ready_i),
      .valid_o    (valid_o),
      .data_o     (data_o),
      .level_o    (level_o),
      .overflow_o (overflow_o)
`ifdef NIBBLE_PACKER_PARITY_EN
      ,
      .parity_o   (parity_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_i = 1'b0;
      data_i  = 4'h0;
      flush_i = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      ready_i = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic send_nib(input logic [3:0] n);
      valid_i = 1'b1;
      data_i  = n;
      step();
      idle();
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int unsigned i = 0; i < 4; i++)
         send_nib(w[i*4 +: 4]);
   endtask

   logic [15:0] words [5];

   initial begin
      words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
      words[3] = 16'hDEF0; words[4] = 16'h0F0F;

      // Reset state
      idle();
      ready_i = 1'b0;
      rst = 1'b1;
      #2;
      check("rst_valid", valid_o, 0);
      check("rst_data", data_o, 0);
      check("rst_level", level_o, 0);
      check("rst_ovf", overflow_o, 0);
      do_reset();

      // Basic word, one-cycle latency, popped immediately
      ready_i = 1'b1;
      send_nib(4'h1); send_nib(4'h2); send_nib(4'h3);
      check("lat_before4", valid_o, 0);
      send_nib(4'h4);
      check("w1_valid", valid_o, 1);
      check("w1_data", data_o, 16'h4321);
      check("w1_level", level_o, 1);
      step();
      check("w1_popped_valid", valid_o, 0);
      check("w1_popped_level", level_o, 0);
      step();
      check("ready_empty_level", level_o, 0);

      // Flush of partial word, then a full word
      ready_i = 1'b0;
      send_nib(4'hA); send_nib(4'hB);
      flush_i = 1'b1;
      step();
      idle();
      check("flush_data", data_o, 16'h00BA);
      check("flush_level", level_o, 1);
      send_word(16'h4321);
      check("after_flush_level", level_o, 2);
      ready_i = 1'b1;
      step();
      check("after_flush_data", data_o, 16'h4321);
      step();
      check("drain_level", level_o, 0);
      ready_i = 1'b0;

      // Flush together with a nibble, then idle flush at count 0
      send_nib(4'hC);
      valid_i = 1'b1; data_i = 4'hD; flush_i = 1'b1;
      step();
      idle();
      check("flushv_data", data_o, 16'h00DC);
      check("flushv_level", level_o, 1);
      flush_i = 1'b1;
      step();
      idle();
      check("noop_flush_level", level_o, 1);
      send_word(16'h4321);
      check("after_flushv_level", level_o, 2);

      // Overflow: five words into DEPTH=4
      do_reset();
      for (int unsigned i = 0; i < 4; i++)
         send_word(words[i]);
      check("full_level", level_o, 4);
      check("full_no_ovf", overflow_o, 0);
      send_word(words[4]);
      check("ovf_level", level_o, 4);
      check("ovf_flag", overflow_o, 1);
      ready_i = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         check($sformatf("drain_%0d", i), data_o, words[i]);
         step();
      end
      ready_i = 1'b0;
      check("drained_level", level_o, 0);
      check("ovf_sticky", overflow_o, 1);
      send_word(16'h4321);
      check("post_drop_word", data_o, 16'h4321);

      // Full FIFO with simultaneous pop on completion: no drop
      do_reset();
      check("ovf_cleared", overflow_o, 0);
      for (int unsigned i = 0; i < 4; i++)
         send_word(words[i]);
      send_nib(4'hF); send_nib(4'h0); send_nib(4'hF);
      ready_i = 1'b1;
      send_nib(4'h0);
      ready_i = 1'b0;
      check("pp_level", level_o, 4);
      check("pp_ovf", overflow_o, 0);
      check("pp_head", data_o, 16'h5678);

      // Asynchronous reset mid-word with words queued
      do_reset();
      send_word(16'h1111);
      send_word(16'h2222);
      send_nib(4'h9); send_nib(4'hA);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", valid_o, 0);
      check("arst_data", data_o, 0);
      check("arst_level", level_o, 0);
      step();
      rst = 1'b0;
      send_nib(4'h5); send_nib(4'h6); send_nib(4'h7); send_nib(4'h8);
      check("arst_word", data_o, 16'h8765);
      check("arst_word_level", level_o, 1);

`ifdef NIBBLE_PACKER_PARITY_EN
      do_reset();
      check("par_rst", parity_o, 0);
      send_word(16'h0001);
      send_word(16'h0003);
      check("par_odd", parity_o, 1);
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      check("par_even_data", data_o, 16'h0003);
      check("par_even", parity_o, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
